// File: rtl/vga_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_regs_pkg
// Purpose  : Register map and 640x480 defaults for the VGA control register bank
// Revision : 1.0 - initial double-buffered release
// ============================================================================
package vga_regs_pkg;

    localparam int unsigned VGA_NUM_REGS   = 11;
    localparam int unsigned VGA_DATA_WIDTH = 8;

    typedef enum logic [3:0] {
        TIMR0  = 4'd0,
        TIMR1  = 4'd1,
        TIMR2  = 4'd2,
        TIMR3  = 4'd3,
        TIMR4  = 4'd4,
        TIMR5  = 4'd5,
        TIMR6  = 4'd6,
        TIMR7  = 4'd7,
        TIMR8  = 4'd8,
        TIMR9  = 4'd9,
        VGACR0 = 4'd10
    } vga_reg_e;

    localparam logic [18:0] VGA_BASE_ADDR = 19'h40000;

    // TIMR9 reports live timing status; VGACR0 (mode control) applies immediately.
    localparam logic [VGA_NUM_REGS-1:0] VGA_RO_MASK     = 11'h200;
    localparam logic [VGA_NUM_REGS-1:0] VGA_SHADOW_MASK = 11'h1FF;

    localparam logic [VGA_NUM_REGS*VGA_DATA_WIDTH-1:0] VGA_RESET_VALUES = {
        8'h81, 8'h00, 8'h21, 8'h02, 8'h0A, 8'h0D,
        8'h30, 8'h60, 8'h12, 8'h50, 8'h64
    };

endpackage : vga_regs_pkg
`default_nettype wire

// File: rtl/vga_reg_cell.sv
`default_nettype none
// ============================================================================
// Module   : vga_reg_cell
// Purpose  : One register slice: staging copy, active copy and dirty flag
// Revision : 1.0 - initial double-buffered release
// ============================================================================
module vga_reg_cell
    import vga_regs_pkg::*;
#(
    parameter int unsigned             DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0,
    parameter bit                      IS_RO       = 1'b0,
    parameter bit                      IS_SHADOW   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  commit,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] staging,
    output logic [DATA_WIDTH-1:0] active,
    output logic                  dirty
);

    localparam logic [DATA_WIDTH-1:0] C_INIT = IS_RO ? '0 : RESET_VALUE;

    logic [DATA_WIDTH-1:0] staging_q, staging_d;
    logic [DATA_WIDTH-1:0] active_q, active_d;
    logic                  dirty_q, dirty_d;

    // Commit reads the pre-write staging value, so a same-edge write re-arms dirty.
    always_comb begin
        staging_d = staging_q;
        active_d  = active_q;
        dirty_d   = dirty_q;
        if (IS_SHADOW) begin
            if (commit && dirty_q) begin
                active_d = staging_q;
                dirty_d  = 1'b0;
            end
            if (wr_en) begin
                staging_d = wdata;
                dirty_d   = 1'b1;
            end
        end else if (wr_en) begin
            staging_d = wdata;
            active_d  = wdata;
        end
        if (IS_RO) begin
            staging_d = '0;
            active_d  = '0;
            dirty_d   = 1'b0;
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            staging_q <= C_INIT;
            active_q  <= C_INIT;
            dirty_q   <= 1'b0;
        end else begin
            staging_q <= staging_d;
            active_q  <= active_d;
            dirty_q   <= dirty_d;
        end
    end

    assign staging = staging_q;
    assign active  = active_q;
    assign dirty   = dirty_q;

endmodule : vga_reg_cell
`default_nettype wire

// File: rtl/vga_control_regfile_db.sv
`default_nettype none
// ============================================================================
// Module   : vga_control_regfile_db
// Purpose  : CPU-mapped VGA control registers, shadowed copies commit on vsync rise
// Revision : 1.0 - initial double-buffered release
// ============================================================================
module vga_control_regfile_db
    import vga_regs_pkg::*;
#(
    parameter int unsigned                          DATA_WIDTH     = 8,
    parameter int unsigned                          ADDR_BUS_WIDTH = 19,
    parameter int unsigned                          REG_ADDR_WIDTH = 4,
    parameter int unsigned                          NUM_REGS       = 11,
    parameter logic [ADDR_BUS_WIDTH-1:0]            BASE_ADDR      = ADDR_BUS_WIDTH'(VGA_BASE_ADDR),
    parameter logic [NUM_REGS-1:0]                  RO_MASK        = '0,
    parameter logic [NUM_REGS-1:0]                  SHADOW_MASK    = '1,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]       RESET_VALUES   = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [DATA_WIDTH-1:0]          data_bus,
    output logic [DATA_WIDTH-1:0]          data_bus_out,
    input  logic [ADDR_BUS_WIDTH-1:0]      addr_bus,
    input  logic                           data_wen,
    output logic                           mux_sel,
    input  logic                           vsync,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] control_reg_out,
    output logic                           commit_pending
);

    logic [DATA_WIDTH-1:0]     w_staging [NUM_REGS];
    logic [DATA_WIDTH-1:0]     w_active  [NUM_REGS];
    logic [NUM_REGS-1:0]       w_dirty;
    logic [NUM_REGS-1:0]       w_wr_en;
    logic                      w_addr_hit;
    logic                      w_wr_hit;
    logic                      w_rd_hit;
    logic                      w_vs_rise;
    logic [REG_ADDR_WIDTH-1:0] w_idx;
    logic [DATA_WIDTH-1:0]     w_rd_data;

    logic                  vsync_q, vsync_d;
    logic                  mux_sel_q, mux_sel_d;
    logic [DATA_WIDTH-1:0] data_bus_out_q, data_bus_out_d;

    assign w_addr_hit = (addr_bus[ADDR_BUS_WIDTH-1:REG_ADDR_WIDTH]
                         == BASE_ADDR[ADDR_BUS_WIDTH-1:REG_ADDR_WIDTH]);
    assign w_idx      = addr_bus[REG_ADDR_WIDTH-1:0];
    assign w_wr_hit   = w_addr_hit && data_wen;
    assign w_rd_hit   = w_addr_hit && !data_wen;
    assign w_vs_rise  = vsync && !vsync_q;

    // Indices past NUM_REGS match no cell, so such writes fall away naturally.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        assign w_wr_en[i] = w_wr_hit && (w_idx == REG_ADDR_WIDTH'(i));

        vga_reg_cell #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH]),
            .IS_RO       (RO_MASK[i]),
            .IS_SHADOW   (SHADOW_MASK[i])
        ) u_cell (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (w_wr_en[i]),
            .commit  (w_vs_rise),
            .wdata   (data_bus),
            .staging (w_staging[i]),
            .active  (w_active[i]),
            .dirty   (w_dirty[i])
        );

        assign control_reg_out[i*DATA_WIDTH +: DATA_WIDTH] = w_active[i];
    end

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == REG_ADDR_WIDTH'(i)) begin
                w_rd_data = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : w_staging[i];
            end
        end
    end

    always_comb begin
        vsync_d        = vsync;
        mux_sel_d      = w_rd_hit;
        data_bus_out_d = data_bus_out_q;
        if (w_rd_hit) begin
            data_bus_out_d = w_rd_data;
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            vsync_q        <= 1'b0;
            mux_sel_q      <= 1'b0;
            data_bus_out_q <= '0;
        end else begin
            vsync_q        <= vsync_d;
            mux_sel_q      <= mux_sel_d;
            data_bus_out_q <= data_bus_out_d;
        end
    end

    assign data_bus_out   = data_bus_out_q;
    assign mux_sel        = mux_sel_q;
    assign commit_pending = |w_dirty;

endmodule : vga_control_regfile_db
`default_nettype wire

// File: tb/tb_vga_control_regfile_db.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_control_regfile_db
// Purpose  : Directed table, vsync corner sequence and random run against a model
// Revision : 1.0 - initial double-buffered release
// ============================================================================
module tb_vga_control_regfile_db;

    localparam int            DW   = 8;
    localparam int            NR   = 11;
    localparam logic [18:0]   BASE = 19'h40000;
    localparam logic [NR-1:0] RO   = 11'h200;
    localparam logic [NR-1:0] SH   = 11'h1FF;
    localparam logic [NR*DW-1:0] RV = {
        8'h81, 8'hEE, 8'h21, 8'h02, 8'h0A, 8'h0D,
        8'h30, 8'h60, 8'h12, 8'h50, 8'h64
    };

    logic              clock;
    logic              reset;
    logic [DW-1:0]     data_bus;
    logic [DW-1:0]     data_bus_out;
    logic [18:0]       addr_bus;
    logic              data_wen;
    logic              mux_sel;
    logic              vsync;
    logic [NR*DW-1:0]  status_in;
    logic [NR*DW-1:0]  control_reg_out;
    logic              commit_pending;

    vga_control_regfile_db #(
        .DATA_WIDTH     (DW),
        .ADDR_BUS_WIDTH (19),
        .REG_ADDR_WIDTH (4),
        .NUM_REGS       (NR),
        .BASE_ADDR      (BASE),
        .RO_MASK        (RO),
        .SHADOW_MASK    (SH),
        .RESET_VALUES   (RV)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .data_bus        (data_bus),
        .data_bus_out    (data_bus_out),
        .addr_bus        (addr_bus),
        .data_wen        (data_wen),
        .mux_sel         (mux_sel),
        .vsync           (vsync),
        .status_in       (status_in),
        .control_reg_out (control_reg_out),
        .commit_pending  (commit_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: plain arrays of staging/active values and dirty flags.
    logic [NR*DW-1:0] rv_v, st_v;
    logic [NR-1:0]    ro_v, sh_v;
    logic [DW-1:0]    m_stg [NR];
    logic [DW-1:0]    m_act [NR];
    logic [NR-1:0]    m_dirty;
    logic             m_vs;
    logic [DW-1:0]    m_dbo;
    logic             m_msel;

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            m_stg[i] = ro_v[i] ? 8'h00 : rv_v[i*DW +: DW];
            m_act[i] = m_stg[i];
        end
        m_dirty = '0;
        m_vs    = 1'b0;
        m_dbo   = '0;
        m_msel  = 1'b0;
    endfunction

    function automatic void model_edge(input logic wen, input logic [18:0] addr,
                                       input logic [DW-1:0] d, input logic vs);
        logic hit;
        int   idx;
        hit = (addr[18:4] == BASE[18:4]);
        idx = int'(addr[3:0]);
        if (vs && !m_vs) begin
            for (int i = 0; i < NR; i++) begin
                if (m_dirty[i]) begin
                    m_act[i]   = m_stg[i];
                    m_dirty[i] = 1'b0;
                end
            end
        end
        m_msel = 1'b0;
        if (hit && wen) begin
            if (idx < NR && !ro_v[idx]) begin
                m_stg[idx] = d;
                if (sh_v[idx]) m_dirty[idx] = 1'b1;
                else           m_act[idx]   = d;
            end
        end else if (hit) begin
            m_msel = 1'b1;
            if (idx >= NR)      m_dbo = 8'h00;
            else if (ro_v[idx]) m_dbo = st_v[idx*DW +: DW];
            else                m_dbo = m_stg[idx];
        end
        m_vs = vs;
    endfunction

    function automatic logic [NR*DW-1:0] model_ctrl();
        logic [NR*DW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = m_act[i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Called just after a rising edge; the DUT updates on the following falling edge.
    task automatic step(input logic wen, input logic [18:0] addr,
                        input logic [DW-1:0] d, input logic vs);
        data_wen = wen;
        addr_bus = addr;
        data_bus = d;
        vsync    = vs;
        @(negedge clock);
        model_edge(wen, addr, d, vs);
        @(posedge clock);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        data_wen = 1'b0;
        vsync    = 1'b0;
        @(negedge clock);
        @(negedge clock);
        model_reset();
        @(posedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        wen;
        logic [18:0] addr;
        logic [7:0]  data;
        logic        vs;
        logic [7:0]  e_dbo;
        logic        e_msel;
        logic        e_pend;
        int          ci;
        logic [7:0]  e_slice;
    } vec_t;

    vec_t tbl[15];

    initial begin
        rv_v = RV;
        ro_v = RO;
        sh_v = SH;
        for (int i = 0; i < NR; i++) st_v[i*DW +: DW] = (i == 9) ? 8'h5C : 8'(8'hE0 + i);
        status_in = st_v;
        addr_bus  = '0;
        data_bus  = '0;

        //            wen   addr        data   vs    dbo    msel  pend  idx slice
        tbl[0]  = '{1'b1, 19'h40002, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 2,  8'h12};
        tbl[1]  = '{1'b0, 19'h40002, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b1, 2,  8'h12};
        tbl[2]  = '{1'b0, 19'h00000, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 2,  8'hA5};
        tbl[3]  = '{1'b1, 19'h4000A, 8'h03, 1'b0, 8'hA5, 1'b0, 1'b0, 10, 8'h03};
        tbl[4]  = '{1'b1, 19'h40001, 8'h11, 1'b0, 8'hA5, 1'b0, 1'b1, 1,  8'h50};
        tbl[5]  = '{1'b1, 19'h40001, 8'h22, 1'b1, 8'hA5, 1'b0, 1'b1, 1,  8'h11};
        tbl[6]  = '{1'b0, 19'h00000, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1, 1,  8'h11};
        tbl[7]  = '{1'b0, 19'h00000, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1,  8'h22};
        tbl[8]  = '{1'b1, 19'h40009, 8'hFF, 1'b1, 8'hA5, 1'b0, 1'b0, 9,  8'h00};
        tbl[9]  = '{1'b0, 19'h40009, 8'h00, 1'b1, 8'h5C, 1'b1, 1'b0, 9,  8'h00};
        tbl[10] = '{1'b0, 19'h4000E, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0,  8'h64};
        tbl[11] = '{1'b1, 19'h40010, 8'h77, 1'b1, 8'h00, 1'b0, 1'b0, 0,  8'h64};
        tbl[12] = '{1'b0, 19'h40010, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0,  8'h64};
        tbl[13] = '{1'b0, 19'h40000, 8'h00, 1'b0, 8'h64, 1'b1, 1'b0, 0,  8'h64};
        tbl[14] = '{1'b0, 19'h40003, 8'h00, 1'b0, 8'h60, 1'b1, 1'b0, 3,  8'h60};

        do_reset();
        chk("reset_reg3", control_reg_out[31:24], 8'h60);
        chk("reset_reg9_ro", control_reg_out[79:72], 8'h00);
        chk("reset_msel", mux_sel, 1'b0);
        chk("reset_dbo", data_bus_out, 8'h00);
        chk("reset_pend", commit_pending, 1'b0);

        for (int r = 0; r < 15; r++) begin
            step(tbl[r].wen, tbl[r].addr, tbl[r].data, tbl[r].vs);
            chk($sformatf("row%0d_dbo", r), data_bus_out, tbl[r].e_dbo);
            chk($sformatf("row%0d_msel", r), mux_sel, tbl[r].e_msel);
            chk($sformatf("row%0d_pend", r), commit_pending, tbl[r].e_pend);
            chk($sformatf("row%0d_reg%0d", r, tbl[r].ci),
                control_reg_out[tbl[r].ci*DW +: DW], tbl[r].e_slice);
        end

        // vsync held high for ten edges must commit exactly once.
        step(1'b1, 19'h40004, 8'h33, 1'b0);
        chk("hold_pre_pend", commit_pending, 1'b1);
        for (int c = 0; c < 10; c++) begin
            if (c == 2) step(1'b1, 19'h40004, 8'h44, 1'b1);
            else        step(1'b0, 19'h00000, 8'h00, 1'b1);
            chk($sformatf("hold%0d_reg4", c), control_reg_out[39:32], 8'h33);
            chk($sformatf("hold%0d_pend", c), commit_pending, (c >= 2) ? 1'b1 : 1'b0);
        end
        step(1'b0, 19'h00000, 8'h00, 1'b0);
        step(1'b0, 19'h00000, 8'h00, 1'b1);
        chk("hold_next_reg4", control_reg_out[39:32], 8'h44);
        chk("hold_next_pend", commit_pending, 1'b0);

        // Pending write discarded by reset mid-frame.
        step(1'b1, 19'h40005, 8'h9A, 1'b0);
        do_reset();
        step(1'b0, 19'h00000, 8'h00, 1'b1);
        chk("rst_discard_reg5", control_reg_out[47:40], 8'h0D);
        chk("rst_discard_pend", commit_pending, 1'b0);

        for (int n = 0; n < 400; n++) begin
            logic [18:0] a;
            logic        v;
            if ($urandom_range(0, 99) == 0) do_reset();
            a = ($urandom_range(0, 9) == 0) ? 19'($urandom) : (BASE | 19'($urandom_range(0, 15)));
            v = ($urandom_range(0, 7) == 0) ? ~m_vs : m_vs;
            step(1'($urandom), a, 8'($urandom), v);
            chk($sformatf("rnd%0d_dbo", n), data_bus_out, m_dbo);
            chk($sformatf("rnd%0d_msel", n), mux_sel, m_msel);
            chk($sformatf("rnd%0d_pend", n), commit_pending, |m_dirty);
            chk($sformatf("rnd%0d_ctrl", n), control_reg_out, model_ctrl());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vga_control_regfile_db
`default_nettype wire

// File: doc/vga_control_regfile_db.md
Name: vga_control_regfile_db

Overview:
Parametrised, double-buffered successor to the VGA MMIO control register bank. It gives the CPU memory bus a configurable window of DATA_WIDTH-bit registers. Each register is read/write, read-only status, or shadowed. Shadowed registers hold CPU writes in a staging copy and commit them to the active copy at the next vertical-sync rising edge, so timing changes never tear a frame. Active copies drive the VGA timing generator.

Parameters:
DATA_WIDTH, 8, width of each register and of the data bus
ADDR_BUS_WIDTH, 19, CPU address bus width
REG_ADDR_WIDTH, 4, low address bits that index the register window
NUM_REGS, 11, implemented registers (must be ≤ 2**REG_ADDR_WIDTH)
BASE_ADDR, 19'h40000, window base; only bits [ADDR_BUS_WIDTH-1:REG_ADDR_WIDTH] are compared
RO_MASK, 0, NUM_REGS bits; bit i=1 makes reg i read-only status
SHADOW_MASK, {NUM_REGS{1'b1}}, bit i=1 makes reg i double-buffered
RESET_VALUES, 0, NUM_REGS*DATA_WIDTH packed reset contents, reg 0 in the LSBs

Ports:
clock  in  1  system clock; all state updates on the falling edge
reset  in  1  synchronous, active-high reset
data_bus  in  DATA_WIDTH  CPU write data
data_bus_out  out  DATA_WIDTH  read data, registered
addr_bus  in  ADDR_BUS_WIDTH  CPU address
data_wen  in  1  1=write, 0=read, qualified by address hit
mux_sel  out  1  1 = this block drives read data onto the CPU bus
vsync  in  1  level vsync from the timing generator; commit on its rising edge
status_in  in  NUM_REGS*DATA_WIDTH  live values returned for RO registers
control_reg_out  out  NUM_REGS*DATA_WIDTH  active register contents, reg i at [DW*(i+1)-1:DW*i]
commit_pending  out  1  OR of all dirty bits

Behaviour:
- Reset: staging[i]=active[i]=RESET_VALUES slice. dirty=0, vsync_q=0, data_bus_out=0, mux_sel=0. A reset during a frame discards pending writes.
- Hit: addr_bus[ADDR_BUS_WIDTH-1:REG_ADDR_WIDTH] == BASE_ADDR[same bits]. idx = addr_bus[REG_ADDR_WIDTH-1:0].
- Write hit, idx<NUM_REGS, not RO:
  - staging[idx] <= data_bus.
  - Non-shadow reg: active[idx] <= data_bus on the same edge, so it is visible on control_reg_out one edge later.
  - Shadow reg: dirty[idx] <= 1.
  - mux_sel <= 0.
- Write hit to an RO reg or to idx≥NUM_REGS: no state change. mux_sel <= 0.
- Read hit: data_bus_out <= status_in slice for RO regs, staging[idx] for RW regs, 0 for idx≥NUM_REGS. mux_sel <= 1. Latency is one edge.
- No hit: mux_sel <= 0. data_bus_out holds its value.
- Commit:
  - vsync_q <= vsync every edge.
  - vs_rise = vsync & ~vsync_q.
  - On vs_rise, every reg with dirty=1 copies active <= staging, and dirty clears.
  - A level held high commits only once.
- Write and vs_rise on the same edge, same shadow reg: commit uses the pre-write staging value. The new write sets dirty=1 again and applies at the following vs_rise.
- Write and vs_rise on the same edge, different regs: both take effect independently.
- RO regs: no staging, no dirty. Their control_reg_out slice is 0.
- commit_pending is combinational from the dirty register.

Decomposition:
- Shared package vga_regs_pkg holds:
  - register index constants (TIMR0..TIMR9=0..9, VGACR0=10);
  - default RESET_VALUES, RO_MASK and SHADOW_MASK for the 640x480 mode;
  - the VGA MMIO BASE_ADDR.
- Sub-module vga_reg_cell: one register slice (staging, active, dirty) with shadow/RO behaviour selected by parameter, instantiated NUM_REGS times in a generate loop. Decode, read mux and vsync edge detect live in the top level.

Test Plan:
- Reset with RESET_VALUES reg3=8'h60 → control_reg_out[31:24]=8'h60, mux_sel=0, data_bus_out=0, commit_pending=0.
- Write 8'hA5 to shadow reg 2 (addr BASE+2) → readback returns 8'hA5 with mux_sel=1 one edge later. control_reg_out[23:16] is unchanged and commit_pending=1 until the vsync rise; the edge after the rise it reads 8'hA5 and commit_pending=0.
- SHADOW_MASK bit 10=0: write 8'h03 to reg 10 → control_reg_out[87:80]=8'h03 one edge later without vsync.
- Write 8'h11 to reg 1 and commit; then write 8'h22 on the same edge as vs_rise → active=8'h11 after that edge, commit_pending=1, and 8'h22 appears after the next vs_rise.
- RO_MASK bit 9=1, status_in reg9=8'h5C: write 8'hFF to reg 9, then read → data_bus_out=8'h5C.
- Read idx 14 (≥NUM_REGS) → data_bus_out=0, mux_sel=1. Access at BASE+16 (outside the window) → mux_sel=0, no state change. vsync held high 10 cycles → exactly one commit.
